// File: rtl/adc_array_sampler_if.sv
// Bus between adc_array_sampler and its surroundings: request/finish toggle
// handshake, run-time averaging depth, the shared ADC control strobes, the
// per-lane serial data and the averaged result vector.
interface adc_array_sampler_if #(
  parameter int N_CH  = 8,
  parameter int ADC_W = 16
);
  logic                    start;
  logic [2:0]              avg_log2;
  logic [N_CH-1:0]         sdo;
  logic                    sclk_ad;
  logic                    cnvst;
  logic [N_CH*ADC_W-1:0]   adc_data;
  logic                    finish;
  logic                    busy;

  // Requester / ADC-bank side.
  modport master (
    output start, avg_log2, sdo,
    input  sclk_ad, cnvst, adc_data, finish, busy
  );

  // Sampler side.
  modport slave (
    input  start, avg_log2, sdo,
    output sclk_ad, cnvst, adc_data, finish, busy
  );
endinterface

// File: rtl/adc_array_sampler.sv
// adc_array_sampler: drives N_CH serial ADCs sharing one cnvst and one sclk_ad,
// shifts in ADC_W-bit MSB-first words on every lane in parallel and averages
// 2^k conversions (k = avg_log2 clamped to MAX_AVG_LOG2).
// Build option: define ADC_SIGNED_EN to treat samples as two's complement
// (sign-extended accumulation, arithmetic divide); otherwise unsigned.
module adc_array_sampler #(
  parameter int N_CH         = 8,
  parameter int ADC_W        = 16,
  parameter int CONV_CYC     = 20,
  parameter int GAP_CYC      = 10,
  parameter int MAX_AVG_LOG2 = 3
) (
  input  logic               clk,
  input  logic               rst,
  adc_array_sampler_if.slave bus
);

  localparam int ACC_W   = ADC_W + MAX_AVG_LOG2;
  localparam int SCNT_W  = MAX_AVG_LOG2 + 1;
  localparam int CNT_MAX = (CONV_CYC > 2*ADC_W)
                         ? ((CONV_CYC > GAP_CYC) ? CONV_CYC : GAP_CYC)
                         : ((2*ADC_W > GAP_CYC) ? 2*ADC_W : GAP_CYC);
  localparam int CNT_W   = $clog2(CNT_MAX);

  localparam logic [CNT_W-1:0] CONV_LAST = CNT_W'(CONV_CYC - 1);
  localparam logic [CNT_W-1:0] ACQ_LAST  = CNT_W'(2*ADC_W - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYC - 1);
  localparam logic [2:0]       K_MAX     = 3'(MAX_AVG_LOG2);

  typedef enum logic [2:0] {IDLE, CONV, ACQ, GAP, DONE} state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 cnvst_q, cnvst_d;
  logic                 sclk_q, sclk_d;
  logic                 busy_q, busy_d;
  logic                 finish_q, finish_d;
  logic [2:0]           k_q;
  logic [SCNT_W-1:0]    sample_cnt_q;
  logic [SCNT_W-1:0]    n_samples;

  logic                 run_start, shift_en, acc_add, result_wr;

  logic [N_CH-1:0][ADC_W-1:0] shreg_q;
  logic [N_CH-1:0][ACC_W-1:0] acc_q;
  logic [N_CH-1:0][ADC_W-1:0] data_q;
  logic [N_CH-1:0][ACC_W-1:0] ext_w;
  logic [N_CH-1:0][ACC_W-1:0] div_w;

  assign n_samples = SCNT_W'(1) << k_q;

  // Per-lane sample extension into the accumulator and the final divide.
  for (genvar g = 0; g < N_CH; g++) begin : g_lane
`ifdef ADC_SIGNED_EN
    assign ext_w[g] = ACC_W'($signed(shreg_q[g]));
    assign div_w[g] = ACC_W'($signed(acc_q[g]) >>> k_q);
`else
    assign ext_w[g] = ACC_W'(shreg_q[g]);
    assign div_w[g] = acc_q[g] >> k_q;
`endif
  end

  // Next-state and registered-output decode for the sequencer.
  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves a
    // signal unassigned, which would otherwise infer a latch.
    state_d   = state_q;
    cnt_d     = cnt_q;
    cnvst_d   = cnvst_q;
    sclk_d    = 1'b0;
    busy_d    = busy_q;
    finish_d  = finish_q;
    run_start = 1'b0;
    shift_en  = 1'b0;
    acc_add   = 1'b0;
    result_wr = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start != finish_q) begin
          run_start = 1'b1;
          cnvst_d   = 1'b1;
          busy_d    = 1'b1;
          cnt_d     = '0;
          state_d   = CONV;
        end
      end
      CONV: begin
        if (cnt_q == CONV_LAST) begin
          cnvst_d = 1'b0;
          sclk_d  = 1'b1;
          cnt_d   = '0;
          state_d = ACQ;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ACQ: begin
        // The edge that takes sclk_ad low is the one that captures sdo.
        shift_en = sclk_q;
        if (cnt_q == ACQ_LAST) begin
          acc_add = 1'b1;
          cnt_d   = '0;
          state_d = GAP;
        end else begin
          cnt_d  = cnt_q + 1'b1;
          sclk_d = ~sclk_q;
        end
      end
      GAP: begin
        if (cnt_q == GAP_LAST) begin
          cnt_d = '0;
          if (sample_cnt_q < n_samples) begin
            cnvst_d = 1'b1;
            state_d = CONV;
          end else begin
            state_d = DONE;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        result_wr = 1'b1;
        finish_d  = ~finish_q;
        busy_d    = 1'b0;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Sequencer state and registered ADC control outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      cnvst_q  <= 1'b0;
      sclk_q   <= 1'b0;
      busy_q   <= 1'b0;
      finish_q <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      cnvst_q  <= cnvst_d;
      sclk_q   <= sclk_d;
      busy_q   <= busy_d;
      finish_q <= finish_d;
    end
  end

  // Lane datapath: shift-in, accumulate, and publish the averaged result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: these lane arrays sit in flops, not RAM, so clearing them on
      // reset is cheap and guarantees an aborted run leaves no residue.
      k_q          <= '0;
      sample_cnt_q <= '0;
      shreg_q      <= '0;
      acc_q        <= '0;
      data_q       <= '0;
    end else begin
      if (run_start) begin
        k_q          <= (bus.avg_log2 > K_MAX) ? K_MAX : bus.avg_log2;
        sample_cnt_q <= '0;
        acc_q        <= '0;
      end
      if (acc_add) sample_cnt_q <= sample_cnt_q + SCNT_W'(1);
      for (int i = 0; i < N_CH; i++) begin
        if (shift_en)  shreg_q[i] <= {shreg_q[i][ADC_W-2:0], bus.sdo[i]};
        if (acc_add)   acc_q[i]   <= acc_q[i] + ext_w[i];
        if (result_wr) data_q[i]  <= div_w[i][ADC_W-1:0];
      end
    end
  end

  assign bus.cnvst    = cnvst_q;
  assign bus.sclk_ad  = sclk_q;
  assign bus.busy     = busy_q;
  assign bus.finish   = finish_q;
  assign bus.adc_data = data_q;

endmodule

// File: tb/tb_adc_array_sampler.sv
// Directed bench for adc_array_sampler with default parameters. A behavioural
// ADC bank loads one word per lane on each cnvst rise (from word_tab, indexed by
// conversion number within the run) and presents MSB first, advancing one bit
// on each falling sclk_ad.
module tb_adc_array_sampler;

  logic clk;
  logic rst;

  adc_array_sampler_if #(.N_CH(8), .ADC_W(16)) bus ();

  adc_array_sampler dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic [15:0] word_tab [8][8];
  logic [15:0] adc_sh   [8];
  logic        cnv_prev = 1'b0;
  int          cnvst_rises = 0;
  int          sclk_rises  = 0;
  int          cnvst_hi    = 0;
  int          conv_base   = 0;

  // ADC bank model: load on cnvst rise, shift on sclk_ad fall.
  always @(bus.cnvst or negedge bus.sclk_ad) begin
    if (bus.cnvst !== cnv_prev) begin
      cnv_prev = bus.cnvst;
      if (bus.cnvst === 1'b1) begin
        for (int i = 0; i < 8; i++) adc_sh[i] = word_tab[i][(cnvst_rises - conv_base) & 7];
        cnvst_rises++;
      end
    end else if (bus.sclk_ad === 1'b0) begin
      for (int i = 0; i < 8; i++) adc_sh[i] = {adc_sh[i][14:0], 1'b0};
    end
  end

  always_comb begin
    for (int i = 0; i < 8; i++) bus.sdo[i] = adc_sh[i][15];
  end

  always @(posedge bus.sclk_ad) sclk_rises++;
  always @(negedge clk) if (bus.cnvst === 1'b1) cnvst_hi++;

  function automatic logic [15:0] lane(input int i);
    logic [127:0] v;
    v = bus.adc_data;
    return v[i*16 +: 16];
  endfunction

  // One run: toggle start, then count negedges until finish matches start.
  task automatic do_run(input logic [2:0] k, output int lat, output int pulses,
                        output int hi, output int sclks, output logic busy0);
    int c0, h0, s0;
    conv_base = cnvst_rises;
    c0 = cnvst_rises; h0 = cnvst_hi; s0 = sclk_rises;
    @(negedge clk);
    bus.avg_log2 = k;
    bus.start = ~bus.start;
    @(negedge clk);
    busy0 = bus.busy;
    lat = 0;
    while (bus.finish !== bus.start && lat < 2000) begin
      @(negedge clk);
      lat++;
    end
    pulses = cnvst_rises - c0;
    hi     = cnvst_hi - h0;
    sclks  = sclk_rises - s0;
  endtask

  task automatic test_reset;
    @(negedge clk);
    n_cmp += 5;
    if (bus.cnvst !== 1'b0) begin n_bad++; $display("FAIL reset_cnvst: got %b want 0", bus.cnvst); end
    if (bus.sclk_ad !== 1'b0) begin n_bad++; $display("FAIL reset_sclk: got %b want 0", bus.sclk_ad); end
    if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    if (bus.finish !== 1'b0) begin n_bad++; $display("FAIL reset_finish: got %b want 0", bus.finish); end
    if (bus.adc_data !== '0) begin n_bad++; $display("FAIL reset_data: got %h want 0", bus.adc_data); end
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_single;
    int lat, pulses, hi, sclks;
    logic b0;
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8; j++) word_tab[i][j] = 16'h1234 + 16'(i);
    do_run(3'd0, lat, pulses, hi, sclks, b0);
    n_cmp += 6;
    if (b0 !== 1'b1) begin n_bad++; $display("FAIL single_busy_accept: got %b want 1", b0); end
    if (lat !== 63) begin n_bad++; $display("FAIL single_latency: got %0d want 63", lat); end
    if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL single_busy_done: got %b want 0", bus.busy); end
    if (pulses !== 1) begin n_bad++; $display("FAIL single_cnvst_pulses: got %0d want 1", pulses); end
    if (hi !== 20) begin n_bad++; $display("FAIL single_cnvst_width: got %0d want 20", hi); end
    if (sclks !== 16) begin n_bad++; $display("FAIL single_sclk_pulses: got %0d want 16", sclks); end
    for (int i = 0; i < 8; i++) begin
      n_cmp++;
      if (lane(i) !== 16'h1234 + 16'(i)) begin
        n_bad++; $display("FAIL single_lane%0d: got %h want %h", i, lane(i), 16'h1234 + 16'(i));
      end
    end
  endtask

  task automatic test_avg4;
    int lat, pulses, hi, sclks;
    logic b0;
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8; j++) word_tab[i][j] = 16'h0A00 + 16'(i);
    word_tab[0][0] = 16'd100; word_tab[0][1] = 16'd101;
    word_tab[0][2] = 16'd102; word_tab[0][3] = 16'd105;
    do_run(3'd2, lat, pulses, hi, sclks, b0);
    n_cmp += 5;
    if (lat !== 249) begin n_bad++; $display("FAIL avg4_latency: got %0d want 249", lat); end
    if (pulses !== 4) begin n_bad++; $display("FAIL avg4_cnvst_pulses: got %0d want 4", pulses); end
    if (sclks !== 64) begin n_bad++; $display("FAIL avg4_sclk_pulses: got %0d want 64", sclks); end
    if (lane(0) !== 16'd102) begin n_bad++; $display("FAIL avg4_lane0: got %0d want 102", lane(0)); end
    if (lane(5) !== 16'h0A05) begin n_bad++; $display("FAIL avg4_lane5: got %h want 0a05", lane(5)); end
  endtask

  task automatic test_no_overflow;
    int lat, pulses, hi, sclks;
    logic b0;
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8; j++) word_tab[i][j] = 16'hFFFF;
    do_run(3'd3, lat, pulses, hi, sclks, b0);
    n_cmp += 1;
    if (lat !== 497) begin n_bad++; $display("FAIL ovf_latency: got %0d want 497", lat); end
    for (int i = 0; i < 8; i++) begin
      n_cmp++;
      if (lane(i) !== 16'hFFFF) begin n_bad++; $display("FAIL ovf_lane%0d: got %h want ffff", i, lane(i)); end
    end
  endtask

  task automatic test_clamp;
    int lat, pulses, hi, sclks;
    logic b0;
    // Lane i, conversion j returns 16*j + i: mean over 8 conversions is 56 + i.
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8; j++) word_tab[i][j] = 16'(16*j + i);
    do_run(3'd7, lat, pulses, hi, sclks, b0);
    n_cmp += 2;
    if (lat !== 497) begin n_bad++; $display("FAIL clamp_latency: got %0d want 497", lat); end
    if (pulses !== 8) begin n_bad++; $display("FAIL clamp_cnvst_pulses: got %0d want 8", pulses); end
    for (int i = 0; i < 8; i += 7) begin
      n_cmp++;
      if (lane(i) !== 16'(56 + i)) begin n_bad++; $display("FAIL clamp_lane%0d: got %0d want %0d", i, lane(i), 56 + i); end
    end
  endtask

  task automatic test_signed;
    int lat, pulses, hi, sclks;
    logic b0;
    logic [15:0] want;
`ifdef ADC_SIGNED_EN
    want = 16'hFFFF;
`else
    want = 16'h7FFF;
`endif
    for (int i = 0; i < 8; i++) begin
      word_tab[i][0] = 16'hFFFE;
      word_tab[i][1] = 16'h0001;
    end
    do_run(3'd1, lat, pulses, hi, sclks, b0);
    n_cmp += 2;
    if (lat !== 125) begin n_bad++; $display("FAIL signed_latency: got %0d want 125", lat); end
    if (lane(3) !== want) begin n_bad++; $display("FAIL signed_lane3: got %h want %h", lane(3), want); end
  endtask

  task automatic test_reset_mid_run;
    int lat, pulses, hi, sclks;
    logic b0;
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8; j++) word_tab[i][j] = 16'h0F00 + 16'(i);
    conv_base = cnvst_rises;
    @(negedge clk);
    bus.avg_log2 = 3'd0;
    bus.start = ~bus.start;
    // Acceptance edge t, ACQ begins at t+20; land inside ACQ cycle 30.
    repeat (50) @(negedge clk);
    n_cmp += 1;
    if (bus.busy !== 1'b1) begin n_bad++; $display("FAIL abort_busy_before: got %b want 1", bus.busy); end
    rst = 1'b1;
    #1;
    n_cmp += 5;
    if (bus.cnvst !== 1'b0) begin n_bad++; $display("FAIL abort_cnvst: got %b want 0", bus.cnvst); end
    if (bus.sclk_ad !== 1'b0) begin n_bad++; $display("FAIL abort_sclk: got %b want 0", bus.sclk_ad); end
    if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL abort_busy: got %b want 0", bus.busy); end
    if (bus.finish !== 1'b0) begin n_bad++; $display("FAIL abort_finish: got %b want 0", bus.finish); end
    if (bus.adc_data !== '0) begin n_bad++; $display("FAIL abort_data: got %h want 0", bus.adc_data); end
    bus.start = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    do_run(3'd0, lat, pulses, hi, sclks, b0);
    n_cmp += 3;
    if (lat !== 63) begin n_bad++; $display("FAIL rerun_latency: got %0d want 63", lat); end
    if (lane(0) !== 16'h0F00) begin n_bad++; $display("FAIL rerun_lane0: got %h want 0f00", lane(0)); end
    if (lane(7) !== 16'h0F07) begin n_bad++; $display("FAIL rerun_lane7: got %h want 0f07", lane(7)); end
  endtask

  initial begin
    clk = 1'b0;
    rst = 1'b1;
    bus.start = 1'b0;
    bus.avg_log2 = 3'd0;
    test_reset();
    test_single();
    test_avg4();
    test_no_overflow();
    test_clamp();
    test_signed();
    test_reset_mid_run();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/adc_array_sampler.md
# adc_array_sampler

Parametrised successor to the 8-channel serial ADC reader. Drives N_CH serial ADCs that share one convert strobe and one serial clock. Captures ADC_W-bit MSB-first words on all lanes in parallel and averages 2^k consecutive conversions, with k selectable at run time. Sits between the PCB ADC bank and the ODE control logic, using the same start/finish toggle handshake as the existing readers.

## Interface
Parameters:
- N_CH, 8: number of ADC lanes.
- ADC_W, 16: bits per conversion.
- CONV_CYC, 20: clk cycles cnvst is held high (≥1).
- GAP_CYC, 10: quiet clk cycles after each readout (≥1).
- MAX_AVG_LOG2, 3: largest supported k.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request toggle; a request is pending while start != finish.
- avg_log2  in  3  requested k; latched on request acceptance; values > MAX_AVG_LOG2 clamp to MAX_AVG_LOG2.
- sdo  in  N_CH  serial data, one bit per lane.
- sclk_ad  out  1  registered serial clock, clk/2 during readout, otherwise low.
- cnvst  out  1  registered convert strobe.
- adc_data  out  N_CH*ADC_W  averaged results; lane i occupies [i*ADC_W +: ADC_W].
- finish  out  1  completion toggle.
- busy  out  1  high from acceptance until the finish toggle edge.

## Operation
- Reset values: sclk_ad=0, cnvst=0, adc_data=0, finish=0, busy=0. Accumulators, counters and shift registers clear; FSM goes to IDLE.
- FSM states: IDLE, CONV, ACQ, GAP, DONE.
- IDLE: if start != finish at an edge, latch k, clear accumulators and sample count, set cnvst=1 and busy=1, go to CONV.
- CONV: hold for CONV_CYC cycles, then cnvst=0 and go to ACQ.
- ACQ: runs 2*ADC_W cycles.
  - sclk_ad is high on the 1st, 3rd, … cycles.
  - Every lane's sdo bit shifts in at the edge that drives sclk_ad from 1 to 0, MSB first.
  - After the last bit, add each lane's word to its accumulator and go to GAP.
- GAP: hold for GAP_CYC cycles with cnvst=0 and sclk_ad=0.
  - If samples taken < 2^k: set cnvst=1 and go to CONV.
  - Otherwise go to DONE.
- DONE (one cycle): adc_data lane i = accumulator_i >> k, truncated to ADC_W bits. Toggle finish, busy=0, return to IDLE.
- Accumulator width is ADC_W+MAX_AVG_LOG2, so it cannot overflow. The result always fits in ADC_W bits.
- start is sampled only in IDLE. A requester must not toggle start again before finish matches it. A double toggle during a run is indistinguishable from no request.
- adc_data holds its value between runs and changes only in DONE.

## Timing
- P = CONV_CYC + 2*ADC_W + GAP_CYC cycles per conversion (default 62).
- Acceptance at edge t: cnvst rises at edge t.
- Finish toggles, and adc_data updates, at edge t + 2^k·P + 1.
- cnvst falls at edge t + CONV_CYC + j·P for conversion j (j = 0 … 2^k−1).
- Back-to-back runs: earliest re-acceptance is the edge after finish toggles.
- Reset asserted mid-run aborts immediately: outputs return to reset values asynchronously and no partial result is written.

## Configuration
- ADC_SIGNED_EN defined:
  - Samples are two's complement.
  - Accumulation sign-extends each sample.
  - The divide is an arithmetic right shift, rounding toward −∞.
- ADC_SIGNED_EN undefined:
  - Samples are unsigned and zero-extended.
  - The divide is a logical right shift.

## Test plan
- Defaults, avg_log2=0, lane i returns 16'h1234+i: finish toggles 63 cycles after acceptance; adc_data lane i = 16'h1234+i; exactly one cnvst pulse 20 cycles wide; 16 sclk_ad pulses.
- avg_log2=2, lane 0 returns 100, 101, 102, 105: 4 cnvst pulses; finish at t+249; lane 0 = 102.
- avg_log2=3, every sample 16'hFFFF on all lanes: result 16'hFFFF on all lanes, showing no accumulator overflow.
- avg_log2=7: clamps to 3; 8 conversions; finish at t+497.
- ADC_SIGNED_EN defined, avg_log2=1, samples 16'hFFFE (−2) and 16'h0001 (+1): result 16'hFFFF (−1).
- rst asserted at cycle 30 of ACQ: cnvst, sclk_ad, busy and finish go to 0 immediately. Previous adc_data is cleared to 0. A new start toggle then completes normally.
